// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared types and constants for the hazard/stall controller
// State encoding, register-zero constant and parameter defaults.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         DEF_TIMEOUT_CYCLES = 64;
  localparam int         DEF_CNT_W          = 16;

  // RAW match of an in-flight writer against the ID-stage sources; r0 never matches.
  function automatic logic raw_match(input logic [4:0] src1,
                                     input logic [4:0] src2,
                                     input logic       two_src,
                                     input logic [4:0] dest,
                                     input logic       wb_en);
    return wb_en && (dest != REG_ZERO) &&
           ((src1 == dest) || (two_src && (src2 == dest)));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// rtl/hazard_stall_controller_sat_counter.sv - saturating performance counter with enable
// Counts enabled cycles and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/RAW stall, memory freeze and branch flush control
// Combinational pipeline controls plus a small memory-wait FSM and stall counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [4:0]       MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             forward_EN,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             hazard_detected,
  output logic             freeze_all,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] wait_cycles
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              freeze_raw;
  logic              raw_exe, raw_mem, raw_hz;

  assign raw_exe = raw_match(src1, src2, two_src, EXE_Dest, EXE_WB_EN);
  assign raw_mem = raw_match(src1, src2, two_src, MEM_Dest, MEM_WB_EN);
  assign raw_hz  = forward_EN ? (raw_exe && EXE_MEM_R_EN) : (raw_exe || raw_mem);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze_raw    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_raw = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request counts as completion, same as mem_ready.
        if (mem_ready || !mem_req) begin
          state_d = RUN;
        end else begin
          freeze_raw = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ERR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        freeze_raw = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Freeze outranks hazard and flush: their inputs are stale while frozen.
  assign freeze_all      = rst_n && freeze_raw;
  assign hazard_detected = rst_n && raw_hz && !branch_taken && !freeze_raw;
  assign flush           = rst_n && branch_taken && !freeze_raw;
  assign mem_timeout     = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hazard_detected),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (freeze_all),
    .count (wait_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scenario bench for hazard_stall_controller
// Small timeout and narrow counters so the timeout and saturation corners are quick to reach.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic [4:0] src1;
    logic [4:0] src2;
    logic       two_src;
    logic [4:0] exe_dest;
    logic       exe_wb;
    logic       exe_ld;
    logic [4:0] mem_dest;
    logic       mem_wb;
    logic       fwd;
    logic       req;
    logic       rdy;
    logic       br;
  } in_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] src1, src2, EXE_Dest, MEM_Dest;
  logic       two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, forward_EN;
  logic       mem_req, mem_ready, branch_taken;
  logic       hazard_detected, freeze_all, flush, mem_timeout;
  logic [2:0] stall_cycles, wait_cycles;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  hazard_stall_controller #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .forward_EN(forward_EN),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .hazard_detected(hazard_detected), .freeze_all(freeze_all), .flush(flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .wait_cycles(wait_cycles)
  );

  function automatic logic [9:0] obs();
    return {hazard_detected, freeze_all, flush, mem_timeout, stall_cycles, wait_cycles};
  endfunction

  function automatic logic [9:0] ex(input logic hz, input logic fa, input logic fl,
                                    input logic to, input int st, input int wt);
    return {hz, fa, fl, to, 3'(st), 3'(wt)};
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.fwd = 1'b1;
    return v;
  endfunction

  function automatic in_t lu();
    in_t v;
    v = idle();
    v.exe_wb = 1'b1;
    v.exe_ld = 1'b1;
    v.exe_dest = 5'd5;
    v.src1 = 5'd5;
    return v;
  endfunction

  task automatic apply(input in_t v);
    src1 = v.src1; src2 = v.src2; two_src = v.two_src;
    EXE_Dest = v.exe_dest; EXE_WB_EN = v.exe_wb; EXE_MEM_R_EN = v.exe_ld;
    MEM_Dest = v.mem_dest; MEM_WB_EN = v.mem_wb; forward_EN = v.fwd;
    mem_req = v.req; mem_ready = v.rdy; branch_taken = v.br;
  endtask

  task automatic drive(input in_t v, input logic [9:0] e);
    @(posedge clk);
    #1;
    apply(v);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(idle());
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    in_t v;
    logic [9:0] got;
    v = lu();
    v.br = 1'b1;
    v.req = 1'b1;
    apply(v);
    rst_n = 1'b0;
    #7;
    got = obs();
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", got, 10'd0);
    end
  endtask

  task automatic test_load_use();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = lu();
      case (i)
        0: drive(v, ex(1, 0, 0, 0, 0, 0));
        1: begin v.exe_ld = 1'b0; drive(v, ex(0, 0, 0, 0, 1, 0)); end
        2: begin v.src1 = 5'd1; v.src2 = 5'd5; v.two_src = 1'b1; drive(v, ex(1, 0, 0, 0, 1, 0)); end
        default: begin v.src1 = 5'd1; v.src2 = 5'd5; drive(v, ex(0, 0, 0, 0, 2, 0)); end
      endcase
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_no_forward();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = idle();
      v.fwd = 1'b0;
      v.mem_wb = 1'b1;
      v.mem_dest = 5'd7;
      v.src1 = 5'd3;
      v.src2 = 5'd7;
      v.two_src = 1'b1;
      case (i)
        0: drive(v, ex(1, 0, 0, 0, 0, 0));
        1: begin v.two_src = 1'b0; drive(v, ex(0, 0, 0, 0, 1, 0)); end
        2: begin v.mem_dest = 5'd0; v.src1 = 5'd0; drive(v, ex(0, 0, 0, 0, 1, 0)); end
        3: begin v.mem_wb = 1'b0; v.exe_wb = 1'b1; v.exe_dest = 5'd9; v.src1 = 5'd9;
                 drive(v, ex(1, 0, 0, 0, 1, 0)); end
        default: drive(idle(), ex(0, 0, 0, 0, 2, 0));
      endcase
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL no_forward row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = idle();
      v.req = 1'b1;
      case (i)
        0: drive(v, ex(0, 1, 0, 0, 0, 0));
        1: drive(v, ex(0, 1, 0, 0, 0, 1));
        2: drive(v, ex(0, 1, 0, 0, 0, 2));
        3: begin v.rdy = 1'b1; drive(v, ex(0, 0, 0, 0, 0, 3)); end
        4: drive(idle(), ex(0, 0, 0, 0, 0, 3));
        5: drive(v, ex(0, 1, 0, 0, 0, 3));
        6: drive(idle(), ex(0, 0, 0, 0, 0, 4));
        default: drive(idle(), ex(0, 0, 0, 0, 0, 4));
      endcase
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mem_wait row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_priority();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = lu();
      v.br = 1'b1;
      case (i)
        0: drive(v, ex(0, 0, 1, 0, 0, 0));
        1: begin v.req = 1'b1; drive(v, ex(0, 1, 0, 0, 0, 0)); end
        2: begin v.req = 1'b1; drive(v, ex(0, 1, 0, 0, 0, 1)); end
        3: begin v.req = 1'b1; v.rdy = 1'b1; drive(v, ex(0, 0, 1, 0, 0, 2)); end
        4: begin v.br = 1'b0; drive(v, ex(1, 0, 0, 0, 0, 2)); end
        default: drive(idle(), ex(0, 0, 0, 0, 1, 2));
      endcase
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL priority row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = lu();
      v.br = 1'b1;
      v.req = 1'b1;
      if (i < 4) drive(v, ex(0, 1, 0, 0, 0, i));
      else if (i == 4) drive(v, ex(0, 1, 0, 1, 0, 4));
      else begin v.rdy = 1'b1; drive(v, ex(0, 1, 0, 1, 0, 5)); end
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout row %0d: got %b expected %b", i, got, e);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_in_err: got %b expected %b", got, 10'd0);
    end
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(lu(), ex(1, 0, 0, 0, (i < 7) ? i : 7, 0));
      else drive(idle(), ex(0, 0, 0, 0, 7, 0));
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL saturation row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_t v;
    logic [9:0] got, e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = idle();
      v.req = 1'b1;
      v.rdy = (i % 2 == 1) || (i == 4);
      case (i)
        0: drive(v, ex(0, 1, 0, 0, 0, 0));
        1: drive(v, ex(0, 0, 0, 0, 0, 1));
        2: drive(v, ex(0, 1, 0, 0, 0, 1));
        3: drive(v, ex(0, 0, 0, 0, 0, 2));
        default: drive(v, ex(0, 0, 0, 0, 0, 2));
      endcase
      @(negedge clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back row %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(idle());
    test_reset();
    test_load_use();
    test_no_forward();
    test_mem_wait();
    test_priority();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
